fibonacci_engine: RTL and testbench

- Iterative Fibonacci calculator, directly downstream of the button debouncer in the fibonacci_2 design.
- The debouncer's one-cycle `debounced_o` pulse drives `start_i`. On each accepted start the block samples an index `n_i` from the switches and computes fib(n) with one addition per cycle.
- It presents the result with a one-cycle completion tick and a sticky overflow flag. The display logic consumes these outputs.

---
 rtl/fibonacci_engine_pkg.sv | 33 +++
 rtl/fibonacci_engine.sv | 84 ++++++++
 tb/tb_fibonacci_engine.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fibonacci_engine_pkg.sv
// Shared types and helpers for the Fibonacci engine.
// The overflow-index helper gives the first n whose fib(n) no longer fits.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  // Smallest n with fib(n) >= 2**result_width (valid for result_width < 64).
  function automatic int unsigned fib_overflow_index(input int unsigned result_width);
    longint unsigned a;
    longint unsigned b;
    longint unsigned t;
    longint unsigned limit;
    int unsigned     idx;
    a     = 0;
    b     = 1;
    idx   = 0;
    limit = 64'd1 << result_width;
    for (int i = 0; i < 93; i++) begin
      if (a < limit) begin
        t   = a + b;
        a   = b;
        b   = t;
        idx = idx + 1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fibonacci_engine.sv
// Iterative Fibonacci calculator: one addition per cycle, one-cycle completion
// tick, saturating result with a sticky overflow flag held until next completion.
//
// state | meaning
// IDLE  | ready for a start; samples n_i on start_i
// OP    | iterating t0/t1 down from cnt=n to 0, or exiting early on overflow
// DONE  | result and overflow valid, done_tick_o high for this one cycle
module fibonacci_engine
  import fib_pkg::*;
#(
  parameter int N_WIDTH      = 5,
  parameter int RESULT_WIDTH = 20
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [N_WIDTH-1:0]      n_i,
  output logic                    ready_o,
  output logic                    done_tick_o,
  output logic                    overflow_o,
  output logic [RESULT_WIDTH-1:0] fib_o
);

  fib_state_e              state;
  logic [RESULT_WIDTH-1:0] t0;
  logic [RESULT_WIDTH-1:0] t1;
  logic [N_WIDTH-1:0]      cnt;
  logic [RESULT_WIDTH:0]   sum;

  assign sum = {1'b0, t0} + {1'b0, t1};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      t0          <= '0;
      t1          <= '0;
      cnt         <= '0;
      fib_o       <= '0;
      overflow_o  <= 1'b0;
      ready_o     <= 1'b1;
      done_tick_o <= 1'b0;
    end else begin
      done_tick_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            t0      <= '0;
            t1      <= RESULT_WIDTH'(1);
            cnt     <= n_i;
            ready_o <= 1'b0;
            state   <= OP;
          end
        end
        OP: begin
          if (cnt == '0) begin
            fib_o       <= t0;
            overflow_o  <= 1'b0;
            done_tick_o <= 1'b1;
            state       <= DONE;
          end else if (sum[RESULT_WIDTH] && (cnt > N_WIDTH'(1))) begin
            // A carry at cnt==1 only lands in t1, which is never returned.
            fib_o       <= '1;
            overflow_o  <= 1'b1;
            done_tick_o <= 1'b1;
            state       <= DONE;
          end else begin
            t0  <= t1;
            t1  <= sum[RESULT_WIDTH-1:0];
            cnt <= cnt - N_WIDTH'(1);
          end
        end
        DONE: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_engine.sv
// Self-checking bench for fibonacci_engine: directed cases plus randomized
// indices against an arithmetic Fibonacci reference.
module tb_fibonacci_engine;

  localparam int NW = 5;
  localparam int RW = 20;

  logic          clk_i;
  logic          rst_ni;
  logic          start_i;
  logic [NW-1:0] n_i;
  logic          ready_o;
  logic          done_tick_o;
  logic          overflow_o;
  logic [RW-1:0] fib_o;

  int n_checks;
  int n_pass;

  logic [RW-1:0] last_fib;
  logic          last_ovf;

  fibonacci_engine #(.N_WIDTH(NW), .RESULT_WIDTH(RW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .n_i         (n_i),
    .ready_o     (ready_o),
    .done_tick_o (done_tick_o),
    .overflow_o  (overflow_o),
    .fib_o       (fib_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Reference: plain Fibonacci arithmetic; saturate when fib(n) doesn't fit.
  // Completion arrives n+2 cycles after start, or at the index of the first
  // unrepresentable term when the run overflows.
  task automatic model(input int n, output logic [RW-1:0] val, output logic ovf, output int lat);
    longint unsigned f[0:40];
    longint unsigned limit;
    int first_big;
    limit = 64'd1 << RW;
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i <= 40; i++) f[i] = f[i-1] + f[i-2];
    first_big = 40;
    for (int i = 40; i >= 0; i--) if (f[i] >= limit) first_big = i;
    ovf = (f[n] >= limit);
    val = ovf ? {RW{1'b1}} : RW'(f[n]);
    lat = ovf ? first_big : n + 2;
  endtask

  // Start a job at cycle 0 and follow it to completion; optionally pulse a
  // second start at cycle 5 and scramble n_i during OP.
  task automatic run_job(input int n, input bit disturb, input string tag);
    logic [RW-1:0] exp_val;
    logic          exp_ovf;
    int            exp_lat;
    int            got_lat;
    model(n, exp_val, exp_ovf, exp_lat);
    start_i = 1'b1;
    n_i     = NW'(n);
    got_lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      if (disturb) begin
        n_i = NW'($urandom);
        if (c == 5) begin
          start_i = 1'b1;
          n_i     = NW'(3);
        end
      end
      if (done_tick_o) begin
        got_lat = c;
        break;
      end
      chk({tag, " ready_low"}, 32'(ready_o), 32'd0);
      chk({tag, " fib_held"}, 32'(fib_o), 32'(last_fib));
      chk({tag, " ovf_held"}, 32'(overflow_o), 32'(last_ovf));
    end
    start_i = 1'b0;
    if (got_lat < 0) chk({tag, " timeout"}, 32'd0, 32'd1);
    chk({tag, " latency"}, 32'(got_lat), 32'(exp_lat));
    chk({tag, " fib"}, 32'(fib_o), 32'(exp_val));
    chk({tag, " ovf"}, 32'(overflow_o), 32'(exp_ovf));
    chk({tag, " ready_in_done"}, 32'(ready_o), 32'd0);
    last_fib = exp_val;
    last_ovf = exp_ovf;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i);
      #1;
      chk({tag, " idle_ready"}, 32'(ready_o), 32'd1);
      chk({tag, " idle_tick"}, 32'(done_tick_o), 32'd0);
      chk({tag, " idle_fib"}, 32'(fib_o), 32'(exp_val));
      chk({tag, " idle_ovf"}, 32'(overflow_o), 32'(exp_ovf));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ready"}, 32'(ready_o), 32'd1);
    chk({tag, " tick"}, 32'(done_tick_o), 32'd0);
    chk({tag, " fib"}, 32'(fib_o), 32'd0);
    chk({tag, " ovf"}, 32'(overflow_o), 32'd0);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    last_fib = '0;
    last_ovf = 1'b0;
    start_i  = 1'b0;
    n_i      = '0;
    rst_ni   = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("rst");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    run_job(0, 1'b0, "n0");
    run_job(1, 1'b0, "n1");
    run_job(10, 1'b0, "n10");
    run_job(30, 1'b0, "n30");
    run_job(31, 1'b0, "n31");
    run_job(2, 1'b0, "n2");
    run_job(10, 1'b1, "n10_dist");

    // Reset mid-OP: abort with no completion tick.
    start_i = 1'b1;
    n_i     = NW'(20);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("abort");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
      chk("abort_no_tick", 32'(done_tick_o), 32'd0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_fib = '0;
    last_ovf = 1'b0;
    @(posedge clk_i);
    #1;
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    run_job(5, 1'b0, "n5_after_rst");

    for (int r = 0; r < 30; r++) begin
      n = int'($urandom_range(0, (1 << NW) - 1));
      run_job(n, (n > 5) ? 1'(($urandom & 1)) : 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
